// File: rtl/iq_mag_sq.sv
// iq_mag_sq: iterative shift-add magnitude-squared (I*I + Q*Q) of one signed
// I/Q sample pair. One product bit is processed per clock, so no multiplier
// is needed. The result width 2*IN_WIDTH matches the square-root radicand.
// Optional feature macro: IQ_MAG_SQ_START_OUT_EN adds the sq_start pulse
// output that can drive the square-root unit's start input directly.
module iq_mag_sq #(
    parameter int IN_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic signed [IN_WIDTH-1:0] i_in,
    input  logic signed [IN_WIDTH-1:0] q_in,
    output logic                       busy,
    output logic                       valid,
`ifdef IQ_MAG_SQ_START_OUT_EN
    output logic                       sq_start,
`endif
    output logic [2*IN_WIDTH-1:0]      mag_sq
);

    localparam int OUT_W = 2 * IN_WIDTH;
    localparam int CNT_W = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(IN_WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SQ_I = 2'd1;
    localparam logic [1:0] S_SQ_Q = 2'd2;

    // Magnitude of a two's-complement value; the most negative input maps to
    // 2^(IN_WIDTH-1), which still fits in IN_WIDTH unsigned bits.
    function automatic logic [IN_WIDTH-1:0] abs_val(input logic signed [IN_WIDTH-1:0] x);
        logic [IN_WIDTH-1:0] u;
        u = x;
        return x[IN_WIDTH-1] ? (~u + 1'b1) : u;
    endfunction

    logic [1:0]          state_q, state_d;
    logic [OUT_W-1:0]    mcand_q, mcand_d;
    logic [IN_WIDTH-1:0] mplier_q, mplier_d;
    logic [IN_WIDTH-1:0] qabs_q, qabs_d;
    logic [OUT_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic [OUT_W-1:0]    mag_q, mag_d;
    logic                sq_start_q, sq_start_d;
    logic [OUT_W-1:0]    addend;
    logic [OUT_W-1:0]    acc_sum;

    // Next-state logic: start always wins (capture/restart), otherwise step
    // one shift-add iteration; Q squaring reuses the accumulator from I.
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        qabs_d     = qabs_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        mag_d      = mag_q;
        sq_start_d = 1'b0;
        addend     = mplier_q[0] ? mcand_q : '0;
        acc_sum    = acc_q + addend;

        if (start) begin
            state_d  = S_SQ_I;
            mcand_d  = OUT_W'(abs_val(i_in));
            mplier_d = abs_val(i_in);
            qabs_d   = abs_val(q_in);
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                S_SQ_I, S_SQ_Q: begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_IT) begin
                        cnt_d = '0;
                        if (state_q == S_SQ_I) begin
                            state_d  = S_SQ_Q;
                            mcand_d  = OUT_W'(qabs_q);
                            mplier_d = qabs_q;
                        end else begin
                            state_d    = S_IDLE;
                            mag_d      = acc_sum;
                            valid_d    = 1'b1;
                            busy_d     = 1'b0;
                            sq_start_d = 1'b1;
                        end
                    end
                end
                S_IDLE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers; asynchronous reset clears everything, aborting any
    // calculation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mcand_q    <= '0;
            mplier_q   <= '0;
            qabs_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            mag_q      <= '0;
            sq_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            qabs_q     <= qabs_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            mag_q      <= mag_d;
            sq_start_q <= sq_start_d;
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign mag_sq = mag_q;
`ifdef IQ_MAG_SQ_START_OUT_EN
    assign sq_start = sq_start_q;
`else
    logic unused_sq_start;
    assign unused_sq_start = sq_start_q;
`endif

endmodule

// File: tb/tb_iq_mag_sq.sv
// Testbench for iq_mag_sq: directed and randomized I/Q pairs checked against
// a plain-arithmetic reference (I*I + Q*Q) with cycle-exact handshake checks.
module tb_iq_mag_sq;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic signed [7:0] i_in;
    logic signed [7:0] q_in;
    logic              busy;
    logic              valid;
    logic [15:0]       mag_sq;
`ifdef IQ_MAG_SQ_START_OUT_EN
    logic              sq_start;
`endif

    int checks   = 0;
    int failures = 0;
    int last_mag = 0;

    iq_mag_sq #(.IN_WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .i_in   (i_in),
        .q_in   (q_in),
        .busy   (busy),
        .valid  (valid),
`ifdef IQ_MAG_SQ_START_OUT_EN
        .sq_start(sq_start),
`endif
        .mag_sq (mag_sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic int ref_mag(input int i, input int q);
        return i * i + q * q;
    endfunction

    // Drive a one-cycle start; afterwards scramble inputs to show they are ignored.
    task automatic launch(input int i, input int q);
        i_in  = 8'(i);
        q_in  = 8'(q);
        start = 1'b1;
        cyc();
        start = 1'b0;
        i_in  = 8'($urandom);
        q_in  = 8'($urandom);
    endtask

    // Check n busy cycles with no valid and the old result held.
    task automatic busy_cycles(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_novalid"}, 32'(valid), 32'd0);
            chk({tag, "_hold"}, 32'(mag_sq), 32'(last_mag));
`ifdef IQ_MAG_SQ_START_OUT_EN
            chk({tag, "_nosq"}, 32'(sq_start), 32'd0);
`endif
            cyc();
        end
    endtask

    // Full 16-cycle calculation then check the completed result.
    task automatic expect_done(input int i, input int q, input string tag);
        busy_cycles(16, tag);
        last_mag = ref_mag(i, q);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_mag"}, 32'(mag_sq), 32'(last_mag));
`ifdef IQ_MAG_SQ_START_OUT_EN
        chk({tag, "_sqpulse"}, 32'(sq_start), 32'd1);
`endif
        cyc();
        chk({tag, "_valid_lvl"}, 32'(valid), 32'd1);
        chk({tag, "_mag_lvl"}, 32'(mag_sq), 32'(last_mag));
`ifdef IQ_MAG_SQ_START_OUT_EN
        chk({tag, "_sqone"}, 32'(sq_start), 32'd0);
`endif
    endtask

    initial begin
        int ri, rq;
        rst_n = 1'b0;
        start = 1'b0;
        i_in  = '0;
        q_in  = '0;
        cyc();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_mag", 32'(mag_sq), 32'd0);
`ifdef IQ_MAG_SQ_START_OUT_EN
        chk("rst_sq", 32'(sq_start), 32'd0);
`endif
        rst_n = 1'b1;
        cyc();

        // Basic and boundary operands
        launch(3, 4);       expect_done(3, 4, "t34");
        launch(-128, -128); expect_done(-128, -128, "tmin");
        launch(127, -1);    expect_done(127, -1, "t127");
        launch(0, 0);       expect_done(0, 0, "tzero");
        for (int k = 0; k < 4; k++) begin
            chk("zero_valid_hold", 32'(valid), 32'd1);
            chk("zero_mag_hold", 32'(mag_sq), 32'd0);
            cyc();
        end

        // Restart while busy: no intermediate valid
        launch(5, 12);
        busy_cycles(5, "abort");
        launch(-7, 24);
        expect_done(-7, 24, "restart");

        // Start coinciding with completion: start wins, old result not written
        launch(6, 8);
        busy_cycles(15, "pre_coin");
        launch(-100, 55);
        expect_done(-100, 55, "coin");

        // Start held for several cycles: last capture wins
        i_in = 8'(1); q_in = 8'(1); start = 1'b1; cyc();
        i_in = 8'(2); q_in = 8'(2); cyc();
        launch(9, 40);
        expect_done(9, 40, "held");

        // Asynchronous reset mid-calculation
        launch(50, -60);
        busy_cycles(8, "pre_rst");
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_mag", 32'(mag_sq), 32'd0);
        last_mag = 0;
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("postrst_novalid", 32'(valid), 32'd0);
            chk("postrst_idle", 32'(busy), 32'd0);
        end

        // Randomized operands against the arithmetic reference
        for (int n = 0; n < 24; n++) begin
            ri = int'($urandom_range(0, 255)) - 128;
            rq = int'($urandom_range(0, 255)) - 128;
            launch(ri, rq);
            expect_done(ri, rq, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
